// File: rtl/alu_control.sv
// Decode-stage ALU control: maps primary opcode and funct/rt field to a
// registered 4-bit ALU operation select consumed by the execute stage.
module alu_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Instruction,
  input  logic [5:0] OpCode,
  output logic [3:0] ALUControl
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_JUMP = 4'd10;

  logic [3:0] w_rtype_ctrl;
  logic [3:0] w_alu_ctrl;
  logic [3:0] r_alu_ctrl;

  // R-type: operation selected by the funct field
  always_comb begin
    w_rtype_ctrl = ALU_ADD;
    case (OpCode)
      6'b100000: w_rtype_ctrl = ALU_ADD;
      6'b100010: w_rtype_ctrl = ALU_SUB;
      6'b100100: w_rtype_ctrl = ALU_AND;
      6'b100101: w_rtype_ctrl = ALU_OR;
      6'b100111: w_rtype_ctrl = ALU_NOR;
      6'b100110: w_rtype_ctrl = ALU_XOR;
      6'b000000: w_rtype_ctrl = ALU_SLL;
      6'b000010: w_rtype_ctrl = ALU_SRL;
      6'b101010: w_rtype_ctrl = ALU_SLT;
      6'b001000: w_rtype_ctrl = ALU_ADD;
      default:   w_rtype_ctrl = ALU_ADD;
    endcase
  end

  // Non-R-type: OpCode is ignored, including rt for REGIMM branches
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (Instruction)
      6'b000000: w_alu_ctrl = w_rtype_ctrl;
      6'b001000: w_alu_ctrl = ALU_ADD;
      6'b011100: w_alu_ctrl = ALU_MUL;
      6'b100011,
      6'b100001,
      6'b100000,
      6'b101011,
      6'b101001,
      6'b101000: w_alu_ctrl = ALU_ADD;
      6'b000001,
      6'b000100,
      6'b000101,
      6'b000111,
      6'b000110: w_alu_ctrl = ALU_SUB;
      6'b000010,
      6'b000011: w_alu_ctrl = ALU_JUMP;
      6'b001100: w_alu_ctrl = ALU_AND;
      6'b001101: w_alu_ctrl = ALU_OR;
      6'b001110: w_alu_ctrl = ALU_XOR;
      6'b001010: w_alu_ctrl = ALU_SLT;
      default:   w_alu_ctrl = ALU_ADD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_alu_ctrl <= ALU_ADD;
    end else begin
      r_alu_ctrl <= w_alu_ctrl;
    end
  end

  assign ALUControl = r_alu_ctrl;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed scenarios plus randomized
// stimulus against a table-driven reference model.
module tb_alu_control;

  logic       Clk;
  logic       Reset;
  logic [5:0] Instruction;
  logic [5:0] OpCode;
  logic [3:0] ALUControl;

  int n_tests;
  int n_fail;

  // Reference tables indexed by field value; entries not listed decode to ADD.
  int funct_tbl [64];
  int opc_tbl   [64];

  alu_control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Instruction (Instruction),
    .OpCode      (OpCode),
    .ALUControl  (ALUControl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic build_model();
    for (int i = 0; i < 64; i++) begin
      funct_tbl[i] = 0;
      opc_tbl[i]   = 0;
    end
    funct_tbl[6'b100000] = 0;  funct_tbl[6'b100010] = 1;
    funct_tbl[6'b100100] = 3;  funct_tbl[6'b100101] = 4;
    funct_tbl[6'b100111] = 5;  funct_tbl[6'b100110] = 6;
    funct_tbl[6'b000000] = 7;  funct_tbl[6'b000010] = 8;
    funct_tbl[6'b101010] = 9;  funct_tbl[6'b001000] = 0;
    opc_tbl[6'b011100] = 2;
    opc_tbl[6'b000001] = 1;  opc_tbl[6'b000100] = 1;  opc_tbl[6'b000101] = 1;
    opc_tbl[6'b000111] = 1;  opc_tbl[6'b000110] = 1;
    opc_tbl[6'b000010] = 10; opc_tbl[6'b000011] = 10;
    opc_tbl[6'b001100] = 3;  opc_tbl[6'b001101] = 4;
    opc_tbl[6'b001110] = 6;  opc_tbl[6'b001010] = 9;
  endtask

  function automatic logic [3:0] model(input logic [5:0] ins, input logic [5:0] op);
    if (ins == 6'd0) return 4'(funct_tbl[op]);
    return 4'(opc_tbl[ins]);
  endfunction

  // Drive inputs mid-cycle, then step past the next rising edge.
  task automatic apply(input logic [5:0] ins, input logic [5:0] op);
    @(negedge Clk);
    Instruction = ins;
    OpCode      = op;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Instruction = 6'b000000;
    OpCode = 6'b100010;
    repeat (2) @(posedge Clk);
    #1;
    n_tests++;
    if (ALUControl !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0d, required 0", ALUControl);
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    n_tests++;
    if (ALUControl !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_release: got %0d, required 1", ALUControl);
    end
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] functs [10] = '{6'b100010, 6'b100000, 6'b001000, 6'b100100, 6'b100101,
                                6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b101010};
    int         expv   [10] = '{1, 0, 0, 3, 4, 5, 6, 7, 8, 9};
    for (int i = 0; i < 10; i++) begin
      apply(6'b000000, functs[i]);
      n_tests++;
      if (ALUControl !== 4'(expv[i])) begin
        n_fail++;
        $display("FAIL rtype_funct_%b: got %0d, required %0d", functs[i], ALUControl, expv[i]);
      end
    end
  endtask

  task automatic test_nonr_arith_mem();
    logic [5:0] opcs [8] = '{6'b001000, 6'b011100, 6'b100011, 6'b100001,
                             6'b100000, 6'b101011, 6'b101001, 6'b101000};
    int         expv [8] = '{0, 2, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      // Seed a nonzero code first so a stuck-at-0 output cannot pass the zero cases.
      apply(6'b000010, 6'b000000);
      apply(opcs[i], 6'b101010);
      n_tests++;
      if (ALUControl !== 4'(expv[i])) begin
        n_fail++;
        $display("FAIL nonr_opcode_%b: got %0d, required %0d", opcs[i], ALUControl, expv[i]);
      end
    end
  endtask

  task automatic test_branches();
    logic [5:0] opcs [6] = '{6'b000001, 6'b000001, 6'b000100, 6'b000101, 6'b000111, 6'b000110};
    logic [5:0] rts  [6] = '{6'b000000, 6'b000001, 6'b100100, 6'b000010, 6'b101010, 6'b111111};
    for (int i = 0; i < 6; i++) begin
      apply(6'b000000, 6'b100000);
      apply(opcs[i], rts[i]);
      n_tests++;
      if (ALUControl !== 4'd1) begin
        n_fail++;
        $display("FAIL branch_%b_rt_%b: got %0d, required 1", opcs[i], rts[i], ALUControl);
      end
    end
  endtask

  task automatic test_jumps_imm();
    logic [5:0] opcs [6] = '{6'b000010, 6'b000011, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    int         expv [6] = '{10, 10, 3, 4, 6, 9};
    for (int i = 0; i < 6; i++) begin
      apply(opcs[i], 6'(i));
      n_tests++;
      if (ALUControl !== 4'(expv[i])) begin
        n_fail++;
        $display("FAIL jump_imm_%b: got %0d, required %0d", opcs[i], ALUControl, expv[i]);
      end
    end
  endtask

  task automatic test_defaults();
    apply(6'b001010, 6'b000000);
    apply(6'b111111, 6'b100010);
    n_tests++;
    if (ALUControl !== 4'd0) begin
      n_fail++;
      $display("FAIL default_opcode_111111: got %0d, required 0", ALUControl);
    end
    apply(6'b001010, 6'b000000);
    apply(6'b000000, 6'b111111);
    n_tests++;
    if (ALUControl !== 4'd0) begin
      n_fail++;
      $display("FAIL default_funct_111111: got %0d, required 0", ALUControl);
    end
  endtask

  task automatic test_hold_between_edges();
    apply(6'b001110, 6'b000000);
    #1 Instruction = 6'b000010;
    #1 OpCode = 6'b101010;
    #4;
    n_tests++;
    if (ALUControl !== 4'd6) begin
      n_fail++;
      $display("FAIL hold_between_edges: got %0d, required 6", ALUControl);
    end
    @(posedge Clk);
    #1;
    n_tests++;
    if (ALUControl !== 4'd10) begin
      n_fail++;
      $display("FAIL hold_next_edge: got %0d, required 10", ALUControl);
    end
  endtask

  task automatic test_reset_midstream();
    apply(6'b000000, 6'b100110);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    n_tests++;
    if (ALUControl !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %0d, required 0", ALUControl);
    end
    @(negedge Clk);
    Reset = 1'b0;
    Instruction = 6'b011100;
    @(posedge Clk);
    #1;
    n_tests++;
    if (ALUControl !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_midstream_release: got %0d, required 2", ALUControl);
    end
  endtask

  task automatic test_random();
    logic [5:0] known [17] = '{6'b001000, 6'b011100, 6'b100011, 6'b100001, 6'b100000,
                               6'b101011, 6'b101001, 6'b101000, 6'b000001, 6'b000100,
                               6'b000101, 6'b000111, 6'b000110, 6'b000010, 6'b000011,
                               6'b001100, 6'b001101};
    logic [5:0] ins;
    logic [5:0] op;
    logic [3:0] exp_code;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       ins = 6'b000000;
        1:       ins = known[$urandom_range(0, 16)];
        default: ins = 6'($urandom);
      endcase
      op = 6'($urandom);
      exp_code = model(ins, op);
      apply(ins, op);
      n_tests++;
      if (ALUControl !== exp_code) begin
        n_fail++;
        $display("FAIL random_%0d ins=%b op=%b: got %0d, required %0d",
                 i, ins, op, ALUControl, exp_code);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Reset = 1'b1;
    Instruction = 6'd0;
    OpCode = 6'd0;
    build_model();
    test_reset();
    test_rtype_sweep();
    test_nonr_arith_mem();
    test_branches();
    test_jumps_imm();
    test_defaults();
    test_hold_between_edges();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
